// File: rtl/adc_dac_pkg.sv
// Shared types and helpers for the multi-channel ADC->DAC scan system.
package adc_dac_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SAMPLE,
      CONVERT,
      DONE
   } state_e;

   // Channel-index width; a single channel still needs one bit.
   function automatic int ch_w(input int num_ch);
      return (num_ch > 1) ? $clog2(num_ch) : 1;
   endfunction

   // LSB position of channel ch in a packed bus of width-bit lanes.
   function automatic int ch_lsb(input int ch, input int width);
      return ch * width;
   endfunction

endpackage

// File: rtl/sar_converter.sv
// Cycle-accurate successive-approximation model: one start cycle, then WIDTH
// trial cycles MSB first. done is asserted during the final trial cycle.
module sar_converter #(
   parameter int WIDTH = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] hold,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam int BW = $clog2(WIDTH);

   logic             active_q;
   logic [BW-1:0]    bit_q;
   logic [WIDTH-1:0] hold_q;
   logic [WIDTH-1:0] result_q;
   logic [WIDTH-1:0] trial;
   logic [WIDTH-1:0] result_d;

   always_comb begin
      trial    = result_q | (WIDTH'(1) << bit_q);
      result_d = (hold_q >= trial) ? trial : result_q;
   end

   // result carries the decided value of the current bit so the caller can
   // latch the final code in the same cycle done is high.
   assign done   = active_q && (bit_q == '0);
   assign result = result_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         active_q <= 1'b0;
         bit_q    <= '0;
         hold_q   <= '0;
         result_q <= '0;
      end else if (start) begin
         active_q <= 1'b1;
         bit_q    <= BW'(WIDTH - 1);
         hold_q   <= hold;
         result_q <= '0;
      end else if (active_q) begin
         result_q <= result_d;
         if (bit_q == '0) begin
            active_q <= 1'b0;
         end else begin
            bit_q <= bit_q - BW'(1);
         end
      end
   end

endmodule

// File: rtl/adc_dac_scan_system.sv
// Periodic round-robin ADC scan: sample timer, scan FSM, SAR converter,
// per-channel DAC hold bank, tagged result stream and sticky overrun flag.
module adc_dac_scan_system
   import adc_dac_pkg::*;
#(
   parameter int WIDTH      = 10,
   parameter int NUM_CH     = 4,
   parameter int SAMPLE_DIV = 64
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      enable,
   input  logic [NUM_CH*WIDTH-1:0]   analog_in,
   input  logic                      overrun_clr,
   output logic [NUM_CH*WIDTH-1:0]   analog_out,
   output logic                      sample_valid,
   output logic [ch_w(NUM_CH)-1:0]   sample_ch,
   output logic [WIDTH-1:0]          sample_data,
   output logic                      busy,
   output logic                      overrun
);

   localparam int                CH_W    = ch_w(NUM_CH);
   localparam int                CNT_W   = $clog2(SAMPLE_DIV);
   localparam logic [CH_W-1:0]   LAST_CH = CH_W'(NUM_CH - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(SAMPLE_DIV - 1);

   state_e                  state_q;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [CH_W-1:0]         ch_q;
   logic [NUM_CH*WIDTH-1:0] dac_q;
   logic [WIDTH-1:0]        sample_data_q;
   logic [CH_W-1:0]         sample_ch_q;
   logic                    sample_valid_q;
   logic                    overrun_q, overrun_d;
   logic                    tick;
   logic                    sar_start, sar_done;
   logic [WIDTH-1:0]        sar_hold, sar_result;

   assign tick = enable && (cnt_q == CNT_MAX);

   // A tick that finds the scan busy is dropped; flagging it beats a clear.
   always_comb begin
      cnt_d = cnt_q + CNT_W'(1);
      if (!enable || tick) begin
         cnt_d = '0;
      end
      overrun_d = overrun_q;
      if (overrun_clr) begin
         overrun_d = 1'b0;
      end
      if (tick && (state_q != IDLE)) begin
         overrun_d = 1'b1;
      end
   end

   assign sar_start = (state_q == SAMPLE);
   assign sar_hold  = analog_in[ch_lsb(int'(ch_q), WIDTH) +: WIDTH];

   sar_converter #(
      .WIDTH (WIDTH)
   ) u_sar (
      .clk    (clk),
      .rst    (rst),
      .start  (sar_start),
      .hold   (sar_hold),
      .done   (sar_done),
      .result (sar_result)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         ch_q           <= '0;
         dac_q          <= '0;
         sample_data_q  <= '0;
         sample_ch_q    <= '0;
         sample_valid_q <= 1'b0;
         overrun_q      <= 1'b0;
      end else begin
         cnt_q          <= cnt_d;
         overrun_q      <= overrun_d;
         sample_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (tick) begin
                  state_q <= SAMPLE;
               end
            end
            SAMPLE: begin
               state_q <= CONVERT;
            end
            CONVERT: begin
               if (sar_done) begin
                  sample_valid_q <= 1'b1;
                  sample_data_q  <= sar_result;
                  sample_ch_q    <= ch_q;
                  state_q        <= DONE;
               end
            end
            DONE: begin
               dac_q[ch_lsb(int'(ch_q), WIDTH) +: WIDTH] <= sample_data_q;
               if (ch_q == LAST_CH) begin
                  ch_q    <= '0;
                  state_q <= IDLE;
               end else begin
                  ch_q    <= ch_q + CH_W'(1);
                  state_q <= SAMPLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign analog_out   = dac_q;
   assign sample_valid = sample_valid_q;
   assign sample_ch    = sample_ch_q;
   assign sample_data  = sample_data_q;
   assign busy         = (state_q != IDLE);
   assign overrun      = overrun_q;

endmodule

// File: tb/tb_adc_dac_scan_system.sv
// Bench for adc_dac_scan_system: default-size scan with scoreboard, an overrun
// instance (SAMPLE_DIV=32) and a single-channel 4-bit instance.
module tb_adc_dac_scan_system;

   localparam int W0 = 10;
   localparam int N0 = 4;

   typedef struct {
      int ch;
      int data;
      int cyc;
   } exp_t;

   typedef struct {
      logic [N0*W0-1:0] ain;
      logic [N0*W0-1:0] exp;
   } vec_t;

   logic clk = 1'b0;
   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Instance 0: defaults
   logic             rst0 = 1'b1, en0 = 1'b0, clr0 = 1'b0;
   logic [N0*W0-1:0] ain0 = '0;
   logic [N0*W0-1:0] aout0;
   logic             v0, busy0, ovr0;
   logic [1:0]       ch0;
   logic [W0-1:0]    d0;

   adc_dac_scan_system u0 (
      .clk (clk), .rst (rst0), .enable (en0), .analog_in (ain0),
      .overrun_clr (clr0), .analog_out (aout0), .sample_valid (v0),
      .sample_ch (ch0), .sample_data (d0), .busy (busy0), .overrun (ovr0)
   );

   // Instance 1: ticks faster than a frame
   logic             rst1 = 1'b1, en1 = 1'b0, clr1 = 1'b0;
   logic [N0*W0-1:0] ain1 = '0;
   logic [N0*W0-1:0] aout1;
   logic             v1, busy1, ovr1;
   logic [1:0]       ch1;
   logic [W0-1:0]    d1;

   adc_dac_scan_system #(.WIDTH(10), .NUM_CH(4), .SAMPLE_DIV(32)) u1 (
      .clk (clk), .rst (rst1), .enable (en1), .analog_in (ain1),
      .overrun_clr (clr1), .analog_out (aout1), .sample_valid (v1),
      .sample_ch (ch1), .sample_data (d1), .busy (busy1), .overrun (ovr1)
   );

   // Instance 2: one channel, 4-bit
   logic       rst2 = 1'b1, en2 = 1'b0, clr2 = 1'b0;
   logic [3:0] ain2 = '0;
   logic [3:0] aout2;
   logic       v2, busy2, ovr2;
   logic [0:0] ch2;
   logic [3:0] d2;

   adc_dac_scan_system #(.WIDTH(4), .NUM_CH(1), .SAMPLE_DIV(16)) u2 (
      .clk (clk), .rst (rst2), .enable (en2), .analog_in (ain2),
      .overrun_clr (clr2), .analog_out (aout2), .sample_valid (v2),
      .sample_ch (ch2), .sample_data (d2), .busy (busy2), .overrun (ovr2)
   );

   exp_t sb[$];
   int   vcount0 = 0, vcount1 = 0, vcount2 = 0;
   bit   pend_vld = 1'b0;
   int   pend_ch = 0;
   int   pend_data = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Pops the scoreboard on every u0 valid; checks the DAC lane one cycle later.
   task automatic monitor();
      exp_t e;
      if (pend_vld) begin
         chk("analog_out_update", aout0[pend_ch*W0 +: W0], pend_data);
         pend_vld = 1'b0;
      end
      if (v0) begin
         vcount0++;
         chk("valid_expected", sb.size() > 0, 1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("sample_ch", ch0, e.ch);
            chk("sample_data", d0, e.data);
            chk("valid_cycle", cyc, e.cyc);
            pend_vld  = 1'b1;
            pend_ch   = e.ch;
            pend_data = e.data;
         end
      end
      if (v1) vcount1++;
      if (v2) vcount2++;
   endtask

   task automatic step();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) step();
   endtask

   function automatic logic [N0*W0-1:0] pack4(input int a0, input int a1, input int a2, input int a3);
      return {W0'(a3), W0'(a2), W0'(a1), W0'(a0)};
   endfunction

   // Drives a frame's inputs shortly before tick tk and queues its results.
   task automatic run_frame(input logic [N0*W0-1:0] ain, input logic [N0*W0-1:0] exp, input int tk);
      exp_t e;
      wait_until(tk - 5);
      ain0 = ain;
      for (int k = 0; k < N0; k++) begin
         e.ch   = k;
         e.data = int'(exp[k*W0 +: W0]);
         e.cyc  = tk + (W0 + 2) * (k + 1);
         sb.push_back(e);
      end
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: bench did not finish by cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t vecs[6];
      int   c0, tk, r, q, vb, c1, t1, c2;

      vecs[0].ain = pack4(0, 1023, 512, 'h2AA);   vecs[0].exp = pack4(0, 1023, 512, 'h2AA);
      vecs[1].ain = pack4(1, 'h155, 'h0F0, 7);    vecs[1].exp = pack4(1, 'h155, 'h0F0, 7);
      vecs[2].ain = pack4(511, 2, 1000, 300);     vecs[2].exp = pack4(511, 2, 1000, 300);
      vecs[3].ain = pack4(512, 'h3FE, 0, 1023);   vecs[3].exp = pack4(512, 'h3FE, 0, 1023);
      vecs[4].ain = pack4(1022, 33, 766, 257);    vecs[4].exp = pack4(1022, 33, 766, 257);
      vecs[5].ain = pack4(1023, 512, 511, 1);     vecs[5].exp = pack4(1023, 512, 511, 1);

      @(posedge clk);
      #1;
      repeat (3) step();

      chk("rst_busy", busy0, 0);
      chk("rst_analog_out", aout0, 0);
      chk("rst_valid", v0, 0);
      chk("rst_overrun", ovr0, 0);
      chk("rst_sample_data", d0, 0);
      chk("rst_sample_ch", ch0, 0);

      // Timer starts at 0 in cycle c0, so the first tick lands at c0+63.
      rst0 = 1'b0;
      en0  = 1'b1;
      c0   = cyc;
      for (int n = 0; n < 6; n++) begin
         run_frame(vecs[n].ain, vecs[n].exp, c0 + 63 + 64 * n);
      end

      // Input change during ch0 conversion must not affect its result.
      tk = c0 + 63 + 64 * 6;
      run_frame(pack4('h2AA, 'h100, 'h200, 'h300), pack4('h2AA, 'h100, 'h200, 'h300), tk);
      wait_until(tk + 5);
      ain0[W0-1:0] = 10'h155;

      // Enable dropped during ch1 conversion: frame completes, then silence.
      tk = c0 + 63 + 64 * 7;
      run_frame(pack4(5, 6, 7, 8), pack4(5, 6, 7, 8), tk);
      wait_until(tk + 16);
      en0 = 1'b0;
      wait_until(tk + 50);
      chk("disable_busy_idle", busy0, 0);
      chk("hold_sample_data", d0, 8);
      chk("hold_sample_ch", ch0, 3);
      vb = vcount0;
      wait_until(tk + 250);
      chk("disable_no_valids", vcount0 - vb, 0);
      chk("disable_still_idle", busy0, 0);

      // Re-enable: first tick SAMPLE_DIV-1 cycles after enable.
      en0 = 1'b1;
      r   = cyc;
      tk  = r + 63;
      run_frame(pack4(9, 10, 11, 12), pack4(9, 10, 11, 12), tk);
      wait_until(tk);
      chk("reenable_idle_at_tick", busy0, 0);
      step();
      chk("reenable_busy_after_tick", busy0, 1);

      // Reset in the middle of a ch0 conversion.
      tk = tk + 64;
      wait_until(tk - 5);
      ain0 = pack4('h155, 'h155, 'h155, 'h155);
      wait_until(tk + 5);
      chk("pre_reset_busy", busy0, 1);
      rst0 = 1'b1;
      #1;
      chk("reset_busy", busy0, 0);
      chk("reset_analog_out", aout0, 0);
      chk("reset_valid", v0, 0);
      chk("reset_sample_data", d0, 0);
      step();
      step();
      rst0 = 1'b0;
      q    = cyc;
      vb   = vcount0;
      tk   = q + 63;
      for (int k = 0; k < N0; k++) begin
         exp_t e;
         e.ch   = k;
         e.data = 'h155;
         e.cyc  = tk + (W0 + 2) * (k + 1);
         sb.push_back(e);
      end
      wait_until(tk + 12);
      chk("post_reset_no_early_valid", vcount0 - vb, 0);
      wait_until(tk + 50);
      chk("post_reset_frame_valids", vcount0 - vb, 4);
      chk("post_reset_idle", busy0, 0);
      en0 = 1'b0;

      // Overrun instance: frame 48 cycles, ticks every 32.
      ain1 = pack4(100, 200, 300, 400);
      rst1 = 1'b0;
      en1  = 1'b1;
      c1   = cyc;
      t1   = c1 + 31;
      wait_until(t1 + 12);
      chk("ovr_ch0_valid", v1, 1);
      chk("ovr_ch0_ch", ch1, 0);
      chk("ovr_ch0_data", d1, 100);
      wait_until(t1 + 32);
      chk("ovr_clear_before_tick", ovr1, 0);
      step();
      chk("ovr_set", ovr1, 1);
      chk("ovr_busy", busy1, 1);
      wait_until(t1 + 48);
      chk("ovr_ch3_valid", v1, 1);
      chk("ovr_ch3_ch", ch1, 3);
      chk("ovr_ch3_data", d1, 400);
      step();
      chk("ovr_frame_valid_count", vcount1, 4);
      chk("ovr_idle_after_frame", busy1, 0);
      chk("ovr_analog_out_ch2", aout1[2*W0 +: W0], 300);
      wait_until(t1 + 70);
      clr1 = 1'b1;
      step();
      clr1 = 1'b0;
      chk("ovr_lone_clear", ovr1, 0);
      wait_until(t1 + 76);
      chk("ovr_next_scan_ch0", v1, 1);
      chk("ovr_next_scan_ch0_id", ch1, 0);
      wait_until(t1 + 96);
      clr1 = 1'b1;
      step();
      clr1 = 1'b0;
      chk("ovr_set_beats_clear", ovr1, 1);
      wait_until(t1 + 100);
      clr1 = 1'b1;
      step();
      clr1 = 1'b0;
      chk("ovr_second_clear", ovr1, 0);
      en1 = 1'b0;

      // Single channel, 4-bit: valid 6 cycles after each tick.
      ain2 = 4'd9;
      rst2 = 1'b0;
      en2  = 1'b1;
      c2   = cyc;
      for (int n = 0; n < 3; n++) begin
         tk = c2 + 15 + 16 * n;
         wait_until(tk + 5);
         chk("one_no_early_valid", v2, 0);
         step();
         chk("one_valid", v2, 1);
         chk("one_ch", ch2, 0);
         chk("one_data", d2, 9);
         step();
         chk("one_analog_out", aout2, 9);
         chk("one_idle", busy2, 0);
      end
      chk("one_valid_count", vcount2, 3);
      chk("one_overrun", ovr2, 0);
      en2 = 1'b0;

      step();
      chk("scoreboard_drained", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/adc_dac_scan_system.md
Name: adc_dac_scan_system

Overview:
Parametrised successor to the single-channel ADC→DAC path. A periodic sample timer launches a round-robin scan over NUM_CH analog inputs. Each channel is converted by a cycle-accurate successive-approximation (SAR) model, and each result is written to a per-channel DAC hold register. It sits between the analog-input bus model and the analog-output bus, and also streams each conversion result with channel tag to downstream logic.

Parameters:
WIDTH, 10, sample/code width in bits (≥2)
NUM_CH, 4, number of analog channels (≥1)
SAMPLE_DIV, 64, clock cycles between scan-start ticks (≥2)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
enable  in  1  runs sample timer; low = timer held at 0, no new ticks
analog_in  in  NUM_CH*WIDTH  channel k at bits [k*WIDTH +: WIDTH]
overrun_clr  in  1  clears sticky overrun flag
analog_out  out  NUM_CH*WIDTH  registered DAC hold values, same packing
sample_valid  out  1  one-cycle pulse per completed conversion
sample_ch  out  CH_W  channel of current sample_data
sample_data  out  WIDTH  converted code
busy  out  1  high whenever FSM not IDLE
overrun  out  1  sticky: tick arrived while busy

Behaviour:
- Reset (async, rst=1): state IDLE; timer=0; ch=0; all dac regs, analog_out, sample_data, sample_ch = 0; sample_valid=busy=overrun=0. Reset mid-conversion aborts immediately; no partial write.
- Timer: counts 0..SAMPLE_DIV-1 while enable; tick when cnt==SAMPLE_DIV-1, then wraps to 0. enable=0 forces cnt to 0 next cycle.
- FSM states: IDLE, SAMPLE, CONVERT, DONE.
  - IDLE: tick → SAMPLE.
  - SAMPLE (1 cycle): hold ← analog_in[ch]; result ← 0; bit ← WIDTH-1 → CONVERT.
  - CONVERT (exactly WIDTH cycles, MSB first): trial = result | (1<<bit); if hold ≥ trial then result ← trial; bit==0 → DONE.
  - DONE (1 cycle): sample_valid=1, sample_ch=ch, sample_data=result; dac[ch] ← result, visible on analog_out the next cycle. If ch==NUM_CH-1: ch ← 0, go to IDLE. Otherwise ch+1, go to SAMPLE.
- Latency: tick in cycle t → SAMPLE t+1 → channel k valid at cycle t+(k+1)*(WIDTH+2). Full frame = NUM_CH*(WIDTH+2) cycles.
- Ideal conversion: sample_data == analog_in value captured in SAMPLE. Input changes after SAMPLE do not affect the result.
- Outputs sample_ch/sample_data hold their last values outside DONE. busy = (state != IDLE).
- Overrun: tick while state != IDLE sets overrun, and that tick is dropped (the scan does not restart). overrun_clr clears it. Simultaneous set and clear → set wins.
- enable dropped mid-frame: the current frame completes. No further ticks.
- NUM_CH=1: ch stays 0, DONE always returns to IDLE.
- Untouched dac registers keep their value indefinitely.

Decomposition:
- Package adc_dac_pkg: state enum (IDLE/SAMPLE/CONVERT/DONE); function/localparam CH_W = max(1, clog2(NUM_CH)); channel-slice helper.
- Sub-module sar_converter (WIDTH parameter): start, hold input, done pulse, result; owns bit counter and trial logic. Top holds timer, scan FSM, channel mux, DAC register bank, overrun.

Test Plan:
- Reset values: assert rst mid-CONVERT with analog_in all 0x155 → within same cycle busy=0, analog_out=0, sample_valid=0; after release, no valid until next tick.
- Basic scan (defaults): analog_in ch0..3 = 0, 1023, 512, 0x2AA; enable at t0 → first tick at t0+63. valid pulses 12,24,36,48 cycles after the tick with ch 0..3 and exact codes. analog_out matches one cycle after each pulse.
- SAR boundaries: codes 0, 1, 511, 512, 1022, 1023 on ch0 → sample_data equals input. Change analog_in mid-CONVERT → result equals value captured in SAMPLE.
- Overrun: SAMPLE_DIV=32, NUM_CH=4 (frame 48) → second tick arrives busy, overrun=1, and the scan does not restart mid-frame. overrun_clr and a coincident tick → overrun stays 1. A lone clr → overrun=0.
- Enable control: drop enable during ch1 conversion → ch2, ch3 still complete, then busy=0 and no further valids for 200 cycles. Re-enable → first tick after SAMPLE_DIV cycles.
- NUM_CH=1, WIDTH=4: analog_in=9 → valid every tick, 6 cycles after tick, sample_ch=0, sample_data=9.
